// File: rtl/regfile_scan_n.sv
// Parametrised register file: two combinational read ports, one synchronous write
// port, optional zero register and write bypass, plus a full serial scan chain.
module regfile_scan_n #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Test,
  input  logic             SDI,
  output logic             SDO,
  input  logic             RegWe,
  input  logic [AW-1:0]    Rw,
  input  logic [WIDTH-1:0] Wd,
  input  logic [AW-1:0]    Rs1,
  input  logic [AW-1:0]    Rs2,
  output logic [WIDTH-1:0] Rd1,
  output logic [WIDTH-1:0] Rd2,
  output logic             ScanWrap
);

  localparam int CHAIN = ZERO_R0 ? WIDTH * (DEPTH - 1) : WIDTH * DEPTH;
  localparam int CW    = $clog2(CHAIN + 1);
  localparam logic [CW-1:0] LAST = CW'(CHAIN - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_cnt;
  logic             r_sdo;
  logic             r_wrap;
  logic [DEPTH-1:0] w_sin;
  logic             w_wr_ok;
  logic             w_byp1;
  logic             w_byp2;

  assign w_wr_ok = RegWe && !(ZERO_R0 && (Rw == '0));

  // Serial input of each register: SDI feeds the first chain register,
  // every other register takes the MSB of its predecessor.
  always_comb begin
    w_sin = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0)
        w_sin[i] = SDI;
      else if (ZERO_R0 && (i == 1))
        w_sin[i] = SDI;
      else
        w_sin[i] = r_mem[i-1][WIDTH-1];
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_sdo  <= 1'b0;
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (Test) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ZERO_R0 && (i == 0))
          r_mem[i] <= '0;
        else
          r_mem[i] <= {r_mem[i][WIDTH-2:0], w_sin[i]};
      end
      r_sdo <= r_mem[DEPTH-1][WIDTH-1];
      if (r_cnt == LAST) begin
        r_cnt  <= '0;
        r_wrap <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_wrap <= 1'b0;
      end
    end else begin
      if (w_wr_ok) r_mem[Rw] <= Wd;
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end
  end

  // Bypass only in functional mode; the zero register is never a bypass target.
  assign w_byp1 = BYPASS && !Test && w_wr_ok && (Rs1 == Rw);
  assign w_byp2 = BYPASS && !Test && w_wr_ok && (Rs2 == Rw);

  always_comb begin
    if (ZERO_R0 && (Rs1 == '0)) Rd1 = '0;
    else if (w_byp1)            Rd1 = Wd;
    else                        Rd1 = r_mem[Rs1];
    if (ZERO_R0 && (Rs2 == '0)) Rd2 = '0;
    else if (w_byp2)            Rd2 = Wd;
    else                        Rd2 = r_mem[Rs2];
  end

  assign SDO      = r_sdo;
  assign ScanWrap = r_wrap;

endmodule

// File: tb/tb_regfile_scan_n.sv
// Directed bench for regfile_scan_n: default instance plus a ZERO_R0=1 instance.
module tb_regfile_scan_n;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        d_Test, d_SDI, d_SDO, d_RegWe, d_ScanWrap;
  logic [2:0]  d_Rw, d_Rs1, d_Rs2;
  logic [15:0] d_Wd, d_Rd1, d_Rd2;
  logic        z_Test, z_SDI, z_SDO, z_RegWe, z_ScanWrap;
  logic [2:0]  z_Rw, z_Rs1, z_Rs2;
  logic [15:0] z_Wd, z_Rd1, z_Rd2;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  regfile_scan_n #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut (
    .Clock(Clock), .nReset(nReset), .Test(d_Test), .SDI(d_SDI), .SDO(d_SDO),
    .RegWe(d_RegWe), .Rw(d_Rw), .Wd(d_Wd), .Rs1(d_Rs1), .Rs2(d_Rs2),
    .Rd1(d_Rd1), .Rd2(d_Rd2), .ScanWrap(d_ScanWrap)
  );

  regfile_scan_n #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1'b1), .BYPASS(1'b1)) dutz (
    .Clock(Clock), .nReset(nReset), .Test(z_Test), .SDI(z_SDI), .SDO(z_SDO),
    .RegWe(z_RegWe), .Rw(z_Rw), .Wd(z_Wd), .Rs1(z_Rs1), .Rs2(z_Rs2),
    .Rd1(z_Rd1), .Rd2(z_Rd2), .ScanWrap(z_ScanWrap)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    #3;
    nReset = 1'b1;
    tick();
  endtask

  task automatic dwrite(input logic [2:0] a, input logic [15:0] v);
    d_RegWe = 1'b1; d_Rw = a; d_Wd = v;
    tick();
    d_RegWe = 1'b0;
  endtask

  task automatic load_count();
    for (int i = 0; i < 8; i++) dwrite(3'(i), 16'(i + 1));
  endtask

  task automatic test_reset();
    dwrite(3'd3, 16'hBEEF);
    d_Rs1 = 3'd3;
    #1;
    if (d_Rd1 !== 16'hBEEF) begin
      errors++; $display("FAIL pre_reset_rd1 got %h want %h", d_Rd1, 16'hBEEF);
    end
    checks++;
    #2;
    nReset = 1'b0;
    #1;
    if (d_Rd1 !== 16'h0000) begin
      errors++; $display("FAIL reset_rd1 got %h want 0000", d_Rd1);
    end
    checks++;
    if (d_SDO !== 1'b0) begin errors++; $display("FAIL reset_sdo got %b want 0", d_SDO); end
    checks++;
    if (d_ScanWrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", d_ScanWrap); end
    checks++;
    nReset = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    dwrite(3'd5, 16'hA5C3);
    d_Rs1 = 3'd5; d_Rs2 = 3'd5;
    #1;
    if (d_Rd1 !== 16'hA5C3) begin errors++; $display("FAIL rd1_reg5 got %h want a5c3", d_Rd1); end
    checks++;
    if (d_Rd2 !== 16'hA5C3) begin errors++; $display("FAIL rd2_reg5 got %h want a5c3", d_Rd2); end
    checks++;
    d_RegWe = 1'b1; d_Rw = 3'd2; d_Wd = 16'h1234; d_Rs1 = 3'd2;
    #1;
    if (d_Rd1 !== 16'h1234) begin errors++; $display("FAIL bypass_rd1 got %h want 1234", d_Rd1); end
    checks++;
    if (d_Rd2 !== 16'hA5C3) begin errors++; $display("FAIL bypass_rd2_other got %h want a5c3", d_Rd2); end
    checks++;
    tick();
    d_RegWe = 1'b0;
    #1;
    if (d_Rd1 !== 16'h1234) begin errors++; $display("FAIL written_reg2 got %h want 1234", d_Rd1); end
    checks++;
  endtask

  task automatic test_zero_r0();
    z_RegWe = 1'b1; z_Rw = 3'd0; z_Wd = 16'hFFFF; z_Rs1 = 3'd0;
    #1;
    if (z_Rd1 !== 16'h0000) begin errors++; $display("FAIL z_bypass_r0 got %h want 0000", z_Rd1); end
    checks++;
    tick();
    z_RegWe = 1'b0;
    #1;
    if (z_Rd1 !== 16'h0000) begin errors++; $display("FAIL z_read_r0 got %h want 0000", z_Rd1); end
    checks++;
    z_RegWe = 1'b1; z_Rw = 3'd1; z_Wd = 16'h8000; z_Rs2 = 3'd1;
    tick();
    z_RegWe = 1'b0;
    #1;
    if (z_Rd2 !== 16'h8000) begin errors++; $display("FAIL z_read_r1 got %h want 8000", z_Rd2); end
    checks++;
    z_Test = 1'b1; z_SDI = 1'b0;
    for (int k = 1; k <= 113; k++) begin
      tick();
      if (z_ScanWrap !== (k == 112)) begin
        errors++; $display("FAIL z_wrap edge %0d got %b want %b", k, z_ScanWrap, (k == 112));
      end
      checks++;
    end
    z_Test = 1'b0;
    tick();
  endtask

  task automatic test_scan_roundtrip();
    logic [15:0] v;
    logic        exp;
    load_count();
    d_Test = 1'b1; d_SDI = 1'b0;
    for (int k = 1; k <= 129; k++) begin
      tick();
      if (k <= 128) begin
        v = 16'(8 - (k - 1) / 16);
        exp = v[15 - (k - 1) % 16];
        if (d_SDO !== exp) begin
          errors++; $display("FAIL rt_sdo edge %0d got %b want %b", k, d_SDO, exp);
        end
        checks++;
      end
      if (d_ScanWrap !== (k == 128)) begin
        errors++; $display("FAIL rt_wrap edge %0d got %b want %b", k, d_ScanWrap, (k == 128));
      end
      checks++;
    end
    d_Test = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d_Rs1 = 3'(i);
      #1;
      if (d_Rd1 !== 16'h0000) begin errors++; $display("FAIL rt_clear reg%0d got %h want 0000", i, d_Rd1); end
      checks++;
    end
    tick();
  endtask

  task automatic test_scan_abort();
    load_count();
    d_Rs1 = 3'd3;
    d_Test = 1'b1; d_SDI = 1'b0; d_RegWe = 1'b1; d_Rw = 3'd3; d_Wd = 16'hFFFF;
    #1;
    if (d_Rd1 !== 16'h0004) begin errors++; $display("FAIL abort_no_bypass got %h want 0004", d_Rd1); end
    checks++;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (d_ScanWrap !== 1'b0) begin errors++; $display("FAIL abort_wrap1 edge %0d got %b want 0", k, d_ScanWrap); end
      checks++;
    end
    d_Test = 1'b0; d_RegWe = 1'b0;
    tick();
    d_Test = 1'b1; d_RegWe = 1'b1; d_Rw = 3'd0;
    for (int k = 1; k <= 128; k++) begin
      tick();
      if (d_ScanWrap !== (k == 128)) begin
        errors++; $display("FAIL abort_wrap2 edge %0d got %b want %b", k, d_ScanWrap, (k == 128));
      end
      checks++;
    end
    d_Test = 1'b0; d_RegWe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d_Rs1 = 3'(i);
      #1;
      if (d_Rd1 !== 16'h0000) begin errors++; $display("FAIL abort_clear reg%0d got %h want 0000", i, d_Rd1); end
      checks++;
    end
    tick();
  endtask

  task automatic test_reset_mid_scan();
    load_count();
    d_Test = 1'b1; d_SDI = 1'b0;
    for (int k = 1; k <= 60; k++) tick();
    #2;
    nReset = 1'b0;
    #1;
    d_Rs1 = 3'd7;
    #1;
    if (d_Rd1 !== 16'h0000) begin errors++; $display("FAIL rms_reg7 got %h want 0000", d_Rd1); end
    checks++;
    if (d_SDO !== 1'b0) begin errors++; $display("FAIL rms_sdo got %b want 0", d_SDO); end
    checks++;
    nReset = 1'b1;
    for (int k = 1; k <= 129; k++) begin
      tick();
      if (d_SDO !== 1'b0) begin errors++; $display("FAIL rms_sdo edge %0d got %b want 0", k, d_SDO); end
      checks++;
      if (d_ScanWrap !== (k == 128)) begin
        errors++; $display("FAIL rms_wrap edge %0d got %b want %b", k, d_ScanWrap, (k == 128));
      end
      checks++;
    end
    d_Test = 1'b0;
    tick();
  endtask

  initial begin
    nReset = 1'b1;
    d_Test = 1'b0; d_SDI = 1'b0; d_RegWe = 1'b0; d_Rw = '0; d_Wd = '0; d_Rs1 = '0; d_Rs2 = '0;
    z_Test = 1'b0; z_SDI = 1'b0; z_RegWe = 1'b0; z_Rw = '0; z_Wd = '0; z_Rs1 = '0; z_Rs2 = '0;
    #2;
    do_reset();
    test_reset();
    test_write_read();
    test_zero_r0();
    test_scan_roundtrip();
    test_scan_abort();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
